input_repeater: RTL and testbench
=================================

INPUT_REPEATER -- requirements
Module: input_repeater

Interface
REQ-001 Parameter DAS_CYCLES, default 8_350_000, meaning: cycles from first pulse to first auto-repeat pulse (~167 ms at 50 MHz).
REQ-002 Parameter ARR_CYCLES, default 2_500_000, meaning: cycles between successive auto-repeat pulses (~50 ms).
REQ-003 Parameter REPEAT_MASK, default 5'b00111, meaning: per-button auto-repeat permission (bit set = repeats).
REQ-004 Port clock  input  1  sole clock, rising edge.
REQ-005 Port resetn  input  1  asynchronous, active-low reset.
REQ-006 Port enable  input  1  game accepts input when high.
REQ-007 Port in_level  input  5  debounced stable button levels: [0] left, [1] right, [2] down, [3] rotate, [4] hard drop.
REQ-008 Port move_pulse  output  5  one-cycle command pulses, same bit order, registered outputs.

Function
REQ-009 Each bit SHALL run an independent channel FSM with states IDLE, DELAY, REPEAT, LOCKOUT and one 24-bit down-counter.
REQ-010 IDLE with in_level=1 and enable=1: pulse asserted the next cycle (1-cycle latency from the sampling edge); go to DELAY with counter=DAS_CYCLES-1 if the REPEAT_MASK bit is set, else go to LOCKOUT.
REQ-011 DELAY: counter decrements each cycle; at 0 the channel pulses and enters REPEAT with counter=ARR_CYCLES-1.
REQ-012 REPEAT: counter decrements; at 0 the channel pulses and reloads ARR_CYCLES-1, so pulse spacing is exactly ARR_CYCLES.
REQ-013 Consequence: the second pulse follows the first by exactly DAS_CYCLES cycles.
REQ-014 In DELAY, REPEAT or LOCKOUT, in_level=0 returns the channel to IDLE on the next edge with no pulse; a press in the following cycle is a new first press.
REQ-015 enable=0 forces every channel to LOCKOUT and suppresses all pulses that cycle.
REQ-016 LOCKOUT leaves only when in_level=0 (to IDLE), so a button held across enable rising never pulses until released and re-pressed.
REQ-017 If channels 0 and 1 both request a pulse in the same cycle, both bits SHALL be 0 in move_pulse; their FSMs advance normally.
REQ-018 Counters SHALL never wrap; a parameter value of 0 is illegal and is rejected by elaboration-time check (DAS_CYCLES, ARR_CYCLES >= 1, < 2^24).

Reset
REQ-019 resetn low SHALL asynchronously force all channels to IDLE, all counters to 0, move_pulse=5'b0.
REQ-020 After deassertion, a button already high produces a first pulse per REQ-010 (reset does not lock out); reset mid-repeat aborts with no further pulses.

Configuration
REQ-021 Macro INPUT_REPEATER_AUTOREPEAT_EN: defined -> behaviour as above; undefined -> REPEAT_MASK is ignored, every channel goes IDLE->LOCKOUT on press (single pulse per press), DELAY/REPEAT and counters are not synthesized.

Structure
REQ-022 Shared package holds the channel state enum (IDLE, DELAY, REPEAT, LOCKOUT), counter width constant CNT_W=24, and button index constants BTN_LEFT..BTN_DROP.
REQ-023 One sub-module repeat_channel (single-button FSM plus counter) SHALL be instantiated 5 times; left/right conflict masking lives in the top level.

Verification (DAS_CYCLES=10, ARR_CYCLES=4 overrides)
REQ-024 Press left for 30 cycles -> pulses at cycles 1, 11, 15, 19, 23, 27 after press; none after release.
REQ-025 Hold rotate for 40 cycles -> exactly one pulse at cycle 1.
REQ-026 Press left and right on the same edge -> move_pulse[1:0]=00 at cycle 1, 11, 15...; release right -> left pulses resume on its schedule.
REQ-027 Hold down while enable=0, raise enable -> no pulse; release 1 cycle, re-press -> pulse at next cycle.
REQ-028 Assert resetn=0 mid-REPEAT between clock edges -> move_pulse=0 immediately; release reset with button held -> first pulse 1 cycle later.
REQ-029 Build without INPUT_REPEATER_AUTOREPEAT_EN, hold left 30 cycles -> single pulse at cycle 1.

Source files
------------

// File: rtl/input_repeater_pkg.sv
// Shared types and constants for the button auto-repeat block.
// The auto-repeat feature is enabled by defining INPUT_REPEATER_AUTOREPEAT_EN.
package input_repeater_pkg;

   localparam int CNT_W = 24;

   localparam int BTN_LEFT   = 0;
   localparam int BTN_RIGHT  = 1;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_ROTATE = 3;
   localparam int BTN_DROP   = 4;
   localparam int NUM_BTN    = 5;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT,
      LOCKOUT
   } ch_state_e;

endpackage

// File: rtl/input_repeater_channel.sv
// Single-button press/auto-repeat FSM; req is the combinational pulse request.
// DELAY/REPEAT and the counter exist only with INPUT_REPEATER_AUTOREPEAT_EN defined.
module repeat_channel
   import input_repeater_pkg::*;
#(
   parameter int unsigned DAS_CYCLES = 8_350_000,
   parameter int unsigned ARR_CYCLES = 2_500_000,
   parameter bit          REPEAT_EN  = 1'b1
) (
   input  logic clock,
   input  logic resetn,
   input  logic enable,
   input  logic level,
   output logic req
);

   ch_state_e state, state_nxt;

`ifdef INPUT_REPEATER_AUTOREPEAT_EN
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req       = 1'b0;
      if (!enable) begin
         state_nxt = LOCKOUT;
      end else begin
         case (state)
            IDLE: if (level) begin
               req = 1'b1;
               if (REPEAT_EN) begin
                  state_nxt = DELAY;
                  cnt_nxt   = CNT_W'(DAS_CYCLES - 1);
               end else begin
                  state_nxt = LOCKOUT;
               end
            end
            DELAY, REPEAT: begin
               if (!level) begin
                  state_nxt = IDLE;
               end else if (cnt == '0) begin
                  req       = 1'b1;
                  state_nxt = REPEAT;
                  cnt_nxt   = CNT_W'(ARR_CYCLES - 1);
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            LOCKOUT: if (!level) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end
`else
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Single pulse per press: every accepted press goes straight to LOCKOUT.
   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      if (!enable) begin
         state_nxt = LOCKOUT;
      end else begin
         case (state)
            IDLE: if (level) begin
               req       = 1'b1;
               state_nxt = LOCKOUT;
            end
            LOCKOUT: if (!level) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end
`endif

endmodule

// File: rtl/input_repeater.sv
// Five-button command pulse generator with optional DAS/ARR auto-repeat
// (INPUT_REPEATER_AUTOREPEAT_EN); left+right in the same cycle cancel each other.
module input_repeater
   import input_repeater_pkg::*;
#(
   parameter int unsigned        DAS_CYCLES  = 8_350_000,
   parameter int unsigned        ARR_CYCLES  = 2_500_000,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK = 5'b00111
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               enable,
   input  logic [NUM_BTN-1:0] in_level,
   output logic [NUM_BTN-1:0] move_pulse
);

   if (DAS_CYCLES == 0 || DAS_CYCLES >= (32'd1 << CNT_W)) begin : g_bad_das
      $error("input_repeater: DAS_CYCLES must be in [1, 2^24)");
   end
   if (ARR_CYCLES == 0 || ARR_CYCLES >= (32'd1 << CNT_W)) begin : g_bad_arr
      $error("input_repeater: ARR_CYCLES must be in [1, 2^24)");
   end

   logic [NUM_BTN-1:0] req, req_masked;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      repeat_channel #(
         .DAS_CYCLES (DAS_CYCLES),
         .ARR_CYCLES (ARR_CYCLES),
         .REPEAT_EN  (REPEAT_MASK[i])
      ) u_ch (
         .clock  (clock),
         .resetn (resetn),
         .enable (enable),
         .level  (in_level[i]),
         .req    (req[i])
      );
   end

   // Opposing directions in the same cycle are ambiguous, so drop both.
   always_comb begin
      req_masked = req;
      if (req[BTN_LEFT] && req[BTN_RIGHT]) begin
         req_masked[BTN_LEFT]  = 1'b0;
         req_masked[BTN_RIGHT] = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) move_pulse <= '0;
      else         move_pulse <= enable ? req_masked : '0;
   end

endmodule

// File: tb/tb_input_repeater.sv
// Scoreboard bench for input_repeater: a press-age reference model predicts
// move_pulse per edge; a negedge monitor pops and compares.
module tb_input_repeater;

   localparam int          DAS  = 10;
   localparam int          ARR  = 4;
   localparam logic [4:0]  MASK = 5'b00111;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic [4:0] in_level = '0;
   logic [4:0] move_pulse;

   input_repeater #(
      .DAS_CYCLES  (DAS),
      .ARR_CYCLES  (ARR),
      .REPEAT_MASK (MASK)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .enable     (enable),
      .in_level   (in_level),
      .move_pulse (move_pulse)
   );

   always #5 clock = ~clock;

   int         checks = 0;
   int         passes = 0;
   logic [4:0] exp_q[$];
   int         pcount[5];
   logic [4:0] mask_v = MASK;

   // Reference model: per button, is a press being tracked, how long, and
   // is the button locked out until release.
   bit m_active[5];
   bit m_locked[5];
   int m_age[5];

   function automatic bit rep_ok(int i);
`ifdef INPUT_REPEATER_AUTOREPEAT_EN
      return mask_v[i];
`else
      return 1'b0;
`endif
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 5; i++) begin
         m_active[i] = 1'b0;
         m_locked[i] = 1'b0;
         m_age[i]    = 0;
      end
   endfunction

   function automatic logic [4:0] model_step(logic en, logic [4:0] lvl);
      logic [4:0] p = '0;
      for (int i = 0; i < 5; i++) begin
         if (!en) begin
            m_active[i] = 1'b0;
            m_locked[i] = 1'b1;
         end else if (m_locked[i]) begin
            if (!lvl[i]) m_locked[i] = 1'b0;
         end else if (!m_active[i]) begin
            if (lvl[i]) begin
               p[i]     = 1'b1;
               m_age[i] = 0;
               if (rep_ok(i)) m_active[i] = 1'b1;
               else           m_locked[i] = 1'b1;
            end
         end else if (!lvl[i]) begin
            m_active[i] = 1'b0;
         end else begin
            m_age[i]++;
            // Pulses at press age DAS, DAS+ARR, DAS+2*ARR, ...
            if (m_age[i] >= DAS && (m_age[i] - DAS) % ARR == 0) p[i] = 1'b1;
         end
      end
      if (p[0] && p[1]) p[1:0] = 2'b00;
      return p;
   endfunction

   task automatic check_vec(string name, logic [4:0] act, logic [4:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
   endtask

   task automatic check_int(string name, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
   endtask

   // Predictor: samples the same inputs the DUT samples on each edge.
   always @(posedge clock) begin
      if (!resetn) begin
         model_reset();
         exp_q.push_back(5'b0);
      end else begin
         exp_q.push_back(model_step(enable, in_level));
      end
   end

   // Monitor.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         logic [4:0] e;
         e = exp_q.pop_front();
         check_vec("move_pulse", move_pulse, e);
         for (int i = 0; i < 5; i++) if (move_pulse[i]) pcount[i]++;
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic clr_counts();
      for (int i = 0; i < 5; i++) pcount[i] = 0;
   endtask

   initial begin
      model_reset();
      clr_counts();
      cyc(3);
      resetn = 1'b1;
      enable = 1'b1;
      cyc(2);

      // Hold left 30 cycles.
      clr_counts();
      in_level = 5'b00001;
      cyc(30);
      in_level = '0;
      cyc(8);
`ifdef INPUT_REPEATER_AUTOREPEAT_EN
      check_int("left_hold_pulses", pcount[0], 6);
`else
      check_int("left_hold_pulses", pcount[0], 1);
`endif

      // Hold rotate 40 cycles: never repeats.
      clr_counts();
      in_level = 5'b01000;
      cyc(40);
      in_level = '0;
      cyc(3);
      check_int("rotate_hold_pulses", pcount[3], 1);

      // Left+right together, then release right.
      clr_counts();
      in_level = 5'b00011;
      cyc(20);
      check_int("lr_conflict_left", pcount[0], 0);
      check_int("lr_conflict_right", pcount[1], 0);
      in_level = 5'b00001;
      cyc(12);
      in_level = '0;
      cyc(3);
`ifdef INPUT_REPEATER_AUTOREPEAT_EN
      check_int("left_resume", pcount[0], 3);
`else
      check_int("left_resume", pcount[0], 0);
`endif

      // Down held across enable rising: locked out until re-press.
      clr_counts();
      enable = 1'b0;
      in_level = 5'b00100;
      cyc(5);
      enable = 1'b1;
      cyc(10);
      check_int("enable_lockout", pcount[2], 0);
      in_level = '0;
      cyc(1);
      in_level = 5'b00100;
      cyc(3);
      check_int("repress_after_lockout", pcount[2], 1);
      in_level = '0;
      cyc(3);

      // Async reset while a pulse is showing, release with button held.
      in_level = 5'b00001;
      cyc(19);
      #1 resetn = 1'b0;
      #1 check_vec("async_reset_clears", move_pulse, 5'b0);
      cyc(2);
      resetn = 1'b1;
      clr_counts();
      cyc(3);
      check_int("first_pulse_after_reset", pcount[0], 1);
      in_level = '0;
      cyc(3);

      // Randomised holds and enable drops.
      for (int n = 0; n < 1500; n++) begin
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, 9) == 0) in_level[b] = ~in_level[b];
         enable = ($urandom_range(0, 39) != 0);
         cyc(1);
      end

      in_level = '0;
      enable = 1'b1;
      cyc(3);
      for (int t = 0; t < 20 && exp_q.size() > 0; t++) cyc(1);
      check_int("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
